// File: rtl/norm_pkg.sv
// Shared types and helpers for the norm_stream pixel normaliser.
package norm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECIP,
    S_WAIT_UP,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_BYPASS    = 2'd0,
    MODE_TRUNC     = 2'd1,
    MODE_ROUND     = 2'd2,
    MODE_TRUNC_ALT = 2'd3
  } mode_t;

  function automatic int beats_per_frame(input int rows, input int cols, input int lanes);
    return (rows * cols) / lanes;
  endfunction

endpackage

// File: rtl/norm_fifo.sv
// Synchronous FIFO with occupancy output; read data is forced to zero while empty.
module norm_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(DEPTH));
  assign wr_en    = push && !full;
  assign rd_en    = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset (and uses non-blocking
  // assignment like all clocked state); validity is tracked by level alone.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/norm_stream.sv
// Frame-based pixel normaliser: out = pix / den scaled to PIX_W bits, via a
// serially computed reciprocal and a one-stage multiplier feeding an output FIFO.
module norm_stream
  import norm_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int LANES      = 1,
  parameter int OUT_ROWS   = 10,
  parameter int OUT_COLS   = 10,
  parameter int FRAC_W     = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             s_axis_resetn,
  input  logic                             ap_start,
  output logic                             ap_ready,
  output logic                             ap_done,
  input  logic                             upstream_done,
  input  logic [PIX_W-1:0]                 norm_denominator,
  input  logic                             norm_denominator_tvalid,
  input  logic [1:0]                       mode,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic [LANES*PIX_W-1:0]           s_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [LANES*PIX_W-1:0]           m_axis_tdata,
  output logic                             m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             err_div0
);

  if ((OUT_ROWS * OUT_COLS) % LANES != 0) begin : g_bad_lanes
    $error("OUT_ROWS*OUT_COLS must be a multiple of LANES");
  end
  if (FRAC_W <= PIX_W) begin : g_bad_frac
    $error("FRAC_W must exceed PIX_W");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two");
  end

  localparam int BEATS = beats_per_frame(OUT_ROWS, OUT_COLS, LANES);
  localparam int DW    = LANES * PIX_W;
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam int CW    = $clog2(BEATS + 1);
  localparam int QW    = FRAC_W + 1;        // den=1 gives 2^FRAC_W
  localparam int IW    = $clog2(QW);
  localparam int RW    = PIX_W + 1;
  localparam int PW    = PIX_W + QW + 1;    // product plus rounding headroom
  localparam int SH    = FRAC_W - PIX_W;
  localparam logic [IW-1:0] TOP_IDX = IW'(FRAC_W);
  localparam logic [PW-1:0] RND     = PW'(1) << (SH - 1);
  localparam logic [PW-1:0] PIX_MAX = PW'((1 << PIX_W) - 1);

  state_t           state;
  logic [PIX_W-1:0] den_q;
  logic             bypass_q;
  logic             round_q;
  logic [QW-1:0]    coef;
  logic [RW-1:0]    rem;
  logic [IW-1:0]    bit_idx;
  logic             up_flag;
  logic [CW-1:0]    in_cnt;

  logic             s1_valid, s1_last, s2_valid, s2_last;
  logic [DW-1:0]    s1_data, s2_data, mult_data;
  logic [DW:0]      fifo_out;
  logic             fifo_empty;
  logic [LW:0]      occ;

  logic             start_fire, in_fire, out_fire;
  logic [RW:0]      den_ext, rem_shift;
  logic             rem_ge;
  logic [PIX_W-1:0] lane_pix;
  logic [PW-1:0]    lane_prod;

  assign start_fire = (state == S_IDLE) && ap_start && norm_denominator_tvalid;
  assign in_fire    = s_axis_tvalid && s_axis_tready;
  assign out_fire   = m_axis_tvalid && m_axis_tready;

  // Beats still in the two pipeline registers must have a FIFO slot reserved.
  assign occ = {1'b0, fifo_level} + (LW+1)'(s1_valid) + (LW+1)'(s2_valid);
  assign s_axis_tready = (state == S_RUN) && (occ < (LW+1)'(FIFO_DEPTH))
                         && (in_cnt < CW'(BEATS));

  // Restoring divider step; the dividend 2^FRAC_W has a single 1 at the top bit.
  assign den_ext   = (RW+1)'(den_q);
  assign rem_shift = {rem, bit_idx == TOP_IDX};
  assign rem_ge    = (rem_shift >= den_ext);

  // NOTE: every variable gets a default before the loop so no latch is
  // inferred; blocking assignment is used because values feed forward in-block.
  always_comb begin
    mult_data = '0;
    lane_pix  = '0;
    lane_prod = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_pix  = s1_data[l*PIX_W +: PIX_W];
      lane_prod = PW'(lane_pix) * PW'(coef);
      if (round_q) lane_prod = lane_prod + RND;
      lane_prod = lane_prod >> SH;
      if (bypass_q)                  mult_data[l*PIX_W +: PIX_W] = lane_pix;
      else if (lane_prod > PIX_MAX)  mult_data[l*PIX_W +: PIX_W] = '1;
      else                           mult_data[l*PIX_W +: PIX_W] = PIX_W'(lane_prod);
    end
  end

  always_ff @(posedge clk) begin
    if (!s_axis_resetn) begin
      state    <= S_IDLE;
      ap_ready <= 1'b1;
      ap_done  <= 1'b0;
      err_div0 <= 1'b0;
      den_q    <= '0;
      bypass_q <= 1'b0;
      round_q  <= 1'b0;
      coef     <= '0;
      rem      <= '0;
      bit_idx  <= '0;
      up_flag  <= 1'b0;
      in_cnt   <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_data  <= '0;
    end else begin
      s1_valid <= in_fire;
      s1_last  <= in_fire && (in_cnt == CW'(BEATS - 1));
      if (in_fire) s1_data <= s_axis_tdata;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      if (s1_valid) s2_data <= mult_data;
      if (in_fire) in_cnt <= in_cnt + CW'(1);
      if (upstream_done && ((state != S_IDLE) || start_fire)) up_flag <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (start_fire) begin
            den_q    <= norm_denominator;
            bypass_q <= (norm_denominator == '0) || (mode_t'(mode) == MODE_BYPASS);
            round_q  <= (mode_t'(mode) == MODE_ROUND);
            if (norm_denominator == '0) err_div0 <= 1'b1;
            coef     <= '0;
            rem      <= '0;
            bit_idx  <= TOP_IDX;
            ap_ready <= 1'b0;
            state    <= S_RECIP;
          end
        end
        S_RECIP: begin
          coef <= {coef[QW-2:0], rem_ge};
          rem  <= RW'(rem_ge ? rem_shift - den_ext : rem_shift);
          if (bit_idx == '0) state <= S_WAIT_UP;
          else               bit_idx <= bit_idx - IW'(1);
        end
        S_WAIT_UP: begin
          if (up_flag) state <= S_RUN;
        end
        S_RUN: begin
          if (out_fire && m_axis_tlast) begin
            ap_done <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          ap_done  <= 1'b0;
          ap_ready <= 1'b1;
          in_cnt   <= '0;
          up_flag  <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  norm_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (s_axis_resetn),
    .push      (s2_valid),
    .push_data ({s2_last, s2_data}),
    .pop       (out_fire),
    .pop_data  (fifo_out),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign {m_axis_tlast, m_axis_tdata} = fifo_out;
  assign m_axis_tvalid = !fifo_empty;

endmodule

// File: tb/tb_norm_stream.sv
// Directed bench for norm_stream (LANES=2, 10x10 frame): vector table of whole
// frames plus hand-written stall and mid-frame reset sequences.
module tb_norm_stream;

  localparam int PIX_W  = 8;
  localparam int LANES  = 2;
  localparam int ROWS   = 10;
  localparam int COLS   = 10;
  localparam int FRAC_W = 24;
  localparam int DEPTH  = 16;
  localparam int NPIX   = ROWS * COLS;
  localparam int BEATS  = NPIX / LANES;

  logic                   clk = 1'b0;
  logic                   s_axis_resetn = 1'b0;
  logic                   ap_start = 1'b0;
  logic                   ap_ready, ap_done;
  logic                   upstream_done = 1'b0;
  logic [PIX_W-1:0]       norm_denominator = '0;
  logic                   norm_denominator_tvalid = 1'b0;
  logic [1:0]             mode = 2'd0;
  logic                   s_axis_tvalid = 1'b0;
  logic                   s_axis_tready;
  logic [LANES*PIX_W-1:0] s_axis_tdata = '0;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready = 1'b0;
  logic [LANES*PIX_W-1:0] m_axis_tdata;
  logic                   m_axis_tlast;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   err_div0;

  always #5 clk = ~clk;

  norm_stream #(
    .PIX_W(PIX_W), .LANES(LANES), .OUT_ROWS(ROWS), .OUT_COLS(COLS),
    .FRAC_W(FRAC_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk                     (clk),
    .s_axis_resetn           (s_axis_resetn),
    .ap_start                (ap_start),
    .ap_ready                (ap_ready),
    .ap_done                 (ap_done),
    .upstream_done           (upstream_done),
    .norm_denominator        (norm_denominator),
    .norm_denominator_tvalid (norm_denominator_tvalid),
    .mode                    (mode),
    .s_axis_tvalid           (s_axis_tvalid),
    .s_axis_tready           (s_axis_tready),
    .s_axis_tdata            (s_axis_tdata),
    .m_axis_tvalid           (m_axis_tvalid),
    .m_axis_tready           (m_axis_tready),
    .m_axis_tdata            (m_axis_tdata),
    .m_axis_tlast            (m_axis_tlast),
    .fifo_level              (fifo_level),
    .err_div0                (err_div0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  logic [7:0] in_pix  [NPIX];
  logic [7:0] exp_pix [NPIX];
  int wait_cyc, prod_timeout, max_level;

  // Reference arithmetic: floor(2^FRAC_W/den), scale, optional rounding, saturate.
  function automatic logic [7:0] model(input logic [7:0] pix, input logic [7:0] den, input logic [1:0] md);
    longint unsigned coef, p;
    if (den == 0 || md == 0) return pix;
    coef = (64'd1 << FRAC_W) / den;
    p = pix * coef;
    if (md == 2) p += 64'd1 << (FRAC_W - PIX_W - 1);
    p = p >> (FRAC_W - PIX_W);
    return (p > 255) ? 8'hFF : p[7:0];
  endfunction

  task automatic fill_const(input logic [7:0] pix, input logic [7:0] expv);
    for (int i = 0; i < NPIX; i++) begin
      in_pix[i]  = pix;
      exp_pix[i] = expv;
    end
  endtask

  task automatic fill_pattern(input logic [7:0] den, input logic [1:0] md);
    for (int i = 0; i < NPIX; i++) begin
      in_pix[i]  = 8'((i * 37 + 11) % 256);
      exp_pix[i] = model(in_pix[i], den, md);
    end
  endtask

  // Drops ap_start, pulses upstream_done during RECIP, then streams the frame.
  task automatic produce();
    int g;
    @(negedge clk);
    ap_start = 1'b0;
    norm_denominator_tvalid = 1'b0;
    wait_cyc = 0;
    prod_timeout = 0;
    s_axis_tdata = {in_pix[1], in_pix[0]};
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && wait_cyc < 200) begin
      upstream_done = (wait_cyc == 2);
      @(negedge clk);
      wait_cyc++;
    end
    upstream_done = 1'b0;
    for (int b = 0; b < BEATS && prod_timeout == 0; b++) begin
      g = 0;
      s_axis_tdata = {in_pix[2*b+1], in_pix[2*b]};
      while (!s_axis_tready && g < 2000) begin
        @(negedge clk);
        g++;
      end
      if (g >= 2000) prod_timeout = 1;
      else @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic consume(input int ready_pct, input int stall, output int beats, output int dones);
    int guard;
    logic held;
    logic [16:0] held_word;
    beats = 0; dones = 0; guard = 0; held = 1'b0; held_word = '0;
    while (beats < BEATS && guard < 4000) begin
      if (held) check("hold_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, held_word});
      if (stall > 0 && guard == stall) begin
        check("stall_level", fifo_level, DEPTH);
        check("stall_tready", s_axis_tready, 0);
      end
      if (fifo_level > max_level) max_level = fifo_level;
      m_axis_tready = (guard >= stall) && ($urandom_range(99) < ready_pct);
      if (m_axis_tvalid && m_axis_tready) begin
        check("beat_data", m_axis_tdata, {exp_pix[2*beats+1], exp_pix[2*beats]});
        check("beat_tlast", m_axis_tlast, beats == BEATS - 1);
        beats++;
        held = 1'b0;
      end else begin
        held = m_axis_tvalid;
        held_word = {m_axis_tlast, m_axis_tdata};
      end
      @(negedge clk);
      guard++;
    end
    m_axis_tready = 1'b0;
    repeat (4) begin
      if (ap_done) dones++;
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] den, input logic [1:0] md,
                           input int ready_pct, input int stall, input logic err_exp);
    int beats, dones;
    max_level = 0;
    norm_denominator = den;
    mode = md;
    norm_denominator_tvalid = 1'b1;
    ap_start = 1'b1;
    fork
      produce();
      consume(ready_pct, stall, beats, dones);
    join
    // FRAC_W+1 divider cycles plus one WAIT_UP cycle before tready can rise.
    check({tag, "_run_entry"}, wait_cyc, FRAC_W + 2);
    check({tag, "_in_timeout"}, prod_timeout, 0);
    check({tag, "_beats"}, beats, BEATS);
    check({tag, "_ap_done_pulses"}, dones, 1);
    check({tag, "_err_div0"}, err_div0, err_exp);
    check({tag, "_ap_ready"}, ap_ready, 1);
    check({tag, "_idle_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_level_bound"}, max_level <= DEPTH, 1);
  endtask

  typedef struct {
    logic [7:0] den;
    logic [1:0] md;
    logic [7:0] pix;
    logic [7:0] expv;
    logic       err;
    int         ready_pct;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'd200, 2'd1, 8'd100, 8'd127, 1'b0, 100};
    vecs[1]  = '{8'd200, 2'd2, 8'd100, 8'd128, 1'b0, 50};
    vecs[2]  = '{8'd200, 2'd2, 8'd200, 8'd255, 1'b0, 100};
    vecs[3]  = '{8'd200, 2'd3, 8'd100, 8'd127, 1'b0, 50};
    vecs[4]  = '{8'd10,  2'd1, 8'd5,   8'd127, 1'b0, 100};
    vecs[5]  = '{8'd10,  2'd2, 8'd5,   8'd128, 1'b0, 100};
    vecs[6]  = '{8'd255, 2'd1, 8'd128, 8'd128, 1'b0, 100};
    vecs[7]  = '{8'd255, 2'd2, 8'd128, 8'd129, 1'b0, 50};
    vecs[8]  = '{8'd1,   2'd1, 8'd255, 8'd255, 1'b0, 100};
    vecs[9]  = '{8'd50,  2'd0, 8'd9,   8'd9,   1'b0, 100};
    vecs[10] = '{8'd0,   2'd1, 8'd77,  8'd77,  1'b1, 100};
    vecs[11] = '{8'd4,   2'd1, 8'd2,   8'd128, 1'b1, 50};

    ap_start = 1'b1;
    s_axis_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ap_ready", ap_ready, 1);
    check("rst_ap_done", ap_done, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_err_div0", err_div0, 0);
    s_axis_resetn = 1'b1;
    s_axis_tvalid = 1'b0;

    // ap_start without a valid denominator must leave the block idle.
    repeat (3) @(negedge clk);
    check("start_no_tvalid_ready", ap_ready, 1);
    check("start_no_tvalid_tready", s_axis_tready, 0);
    ap_start = 1'b0;

    for (int i = 0; i < 12; i++) begin
      fill_const(vecs[i].pix, vecs[i].expv);
      run_frame($sformatf("vec%0d", i), vecs[i].den, vecs[i].md, vecs[i].ready_pct, 0, vecs[i].err);
    end

    fill_pattern(8'd7, 2'd2);
    run_frame("pattern_rand_ready", 8'd7, 2'd2, 50, 0, 1'b1);
    fill_pattern(8'd0, 2'd2);
    run_frame("pattern_div0_bypass", 8'd0, 2'd2, 50, 0, 1'b1);
    fill_pattern(8'd200, 2'd1);
    run_frame("stall40", 8'd200, 2'd1, 100, 70, 1'b1);

    // Reset in the middle of a frame with data parked in the FIFO.
    norm_denominator = 8'd10;
    mode = 2'd1;
    norm_denominator_tvalid = 1'b1;
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    norm_denominator_tvalid = 1'b0;
    upstream_done = 1'b1;
    @(negedge clk);
    upstream_done = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 16'h0505;
    wait_cyc = 0;
    while (!s_axis_tready && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("midrun_reached_run", s_axis_tready, 1);
    repeat (10) @(negedge clk);
    check("midrun_level_nonzero", fifo_level != 0, 1);
    s_axis_resetn = 1'b0;
    @(negedge clk);
    check("midrun_rst_ap_ready", ap_ready, 1);
    check("midrun_rst_m_tvalid", m_axis_tvalid, 0);
    check("midrun_rst_level", fifo_level, 0);
    check("midrun_rst_s_tready", s_axis_tready, 0);
    check("midrun_rst_err_div0", err_div0, 0);
    check("midrun_rst_ap_done", ap_done, 0);
    s_axis_resetn = 1'b1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);

    fill_pattern(8'd9, 2'd1);
    run_frame("after_reset", 8'd9, 2'd1, 50, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/norm_stream.md
NORM_STREAM -- requirements
Module: norm_stream

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter LANES, default 1, pixels per stream beat.
REQ-003 SHALL have parameters OUT_ROWS and OUT_COLS, default 10 each, image size; OUT_ROWS*OUT_COLS SHALL be a multiple of LANES (elaboration error otherwise).
REQ-004 SHALL have parameter FRAC_W, default 24, reciprocal fraction bits; FRAC_W > PIX_W.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, output FIFO depth in beats (power of 2).
REQ-006 SHALL have port clk, in, 1, the single clock.
REQ-007 SHALL have port s_axis_resetn, in, 1, reset: synchronous, active-low.
REQ-008 SHALL have ports ap_start (in, 1), ap_ready (out, 1), ap_done (out, 1): frame control.
REQ-009 SHALL have port upstream_done, in, 1, pulse meaning the upstream crop stage has finished a frame.
REQ-010 SHALL have ports norm_denominator (in, PIX_W) and norm_denominator_tvalid (in, 1).
REQ-011 SHALL have port mode, in, 2: 0 bypass, 1 divide-truncate, 2 divide-round, 3 same as 1.
REQ-012 SHALL have ports s_axis_tvalid (in, 1), s_axis_tready (out, 1), s_axis_tdata (in, LANES*PIX_W), lane 0 in LSBs.
REQ-013 SHALL have ports m_axis_tvalid (out, 1), m_axis_tready (in, 1), m_axis_tdata (out, LANES*PIX_W), m_axis_tlast (out, 1).
REQ-014 SHALL have ports fifo_level (out, clog2(FIFO_DEPTH)+1) and err_div0 (out, 1, sticky).

Function
REQ-015 SHALL implement FSM states IDLE, RECIP, WAIT_UP, RUN, DONE; ap_ready=1 only in IDLE.
REQ-016 IDLE->RECIP SHALL occur when ap_start && norm_denominator_tvalid; it latches norm_denominator and mode; ap_start without tvalid, or in any non-IDLE state, is ignored.
REQ-017 RECIP SHALL compute coef = floor(2^FRAC_W / den) with an iterative restoring divider in exactly FRAC_W+1 cycles, then go to WAIT_UP.
REQ-018 den=0 SHALL set err_div0 and force bypass for that frame; err_div0 clears only on reset.
REQ-019 upstream_done SHALL be captured in a sticky flag from IDLE exit onward, so a pulse during RECIP is not lost; WAIT_UP->RUN when the flag is set.
REQ-020 In RUN, s_axis_tready SHALL equal (FIFO has room for one beat incl. in-flight beat) && (input beats < OUT_ROWS*OUT_COLS/LANES); tready=0 in all other states.
REQ-021 Per lane, divide modes SHALL compute p = pix*coef (PIX_W+FRAC_W bits); round adds 2^(FRAC_W-PIX_W-1); out = min(2^PIX_W-1, p >> (FRAC_W-PIX_W)).
REQ-022 Bypass SHALL pass pixels unchanged.
REQ-023 Multiply stage SHALL be one registered pipeline stage; an accepted input beat SHALL be visible at m_axis_tvalid no earlier than 2 cycles after acceptance.
REQ-024 m_axis_tlast SHALL be 1 exactly on the final beat of the frame.
REQ-025 RUN->DONE SHALL occur in the cycle the tlast beat is accepted (m_axis_tvalid && m_axis_tready && m_axis_tlast).
REQ-026 ap_done SHALL be a one-cycle pulse in DONE, followed by IDLE; beat counters and the upstream_done flag clear on DONE.
REQ-027 FIFO full SHALL never drop data (tready gating); FIFO empty SHALL hold m_axis_tvalid=0; simultaneous push and pop SHALL keep fifo_level unchanged.
REQ-028 Once m_axis_tvalid=1, m_axis_tdata and m_axis_tlast SHALL stay stable until accepted.

Reset
REQ-029 On s_axis_resetn=0 at a clk edge (any state): FSM to IDLE, FIFO flushed, counters, flags, coef and err_div0 cleared.
REQ-030 Reset values: ap_ready=1, ap_done=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, fifo_level=0, err_div0=0; m_axis_tdata=0.

Structure
REQ-031 Package norm_pkg SHALL hold the FSM state enum, mode encodings and a function computing beats-per-frame.
REQ-032 The output buffer SHALL be a sub-module norm_fifo (synchronous FIFO with level output); divider and multiplier stay in norm_stream.

Verification
REQ-033 den=200, mode=1, pix=100 -> out 127; mode=2 -> 128; pix=200 mode=2 -> 255 (saturated).
REQ-034 upstream_done pulsed 3 cycles after ap_start (during RECIP) -> enters RUN after FRAC_W+1 cycles; no hang.
REQ-035 LANES=2, 10x10 frame, m_axis_tready random 50% -> 50 beats out, tlast only on beat 50, one ap_done pulse, no loss.
REQ-036 den=0 -> err_div0=1, output equals input; second frame den=4 -> err_div0 still 1, pix=2 out=128 (mode 1).
REQ-037 m_axis_tready=0 for 40 cycles -> fifo_level saturates at FIFO_DEPTH, s_axis_tready=0, zero drops.
REQ-038 Reset asserted mid-RUN -> next cycle IDLE, ap_ready=1, m_axis_tvalid=0, fifo_level=0; new frame then runs clean.
